handshake_arbiter: RTL and testbench

//   Round-robin arbiter sharing one 4-phase req/ack accumulator port among N_REQ requesters.

---
 rtl/handshake_arbiter.sv | 90 +++++++++
 tb/tb_handshake_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/handshake_arbiter.sv
// handshake_arbiter: round-robin 4-phase req/ack arbiter in front of a single accumulator port
module handshake_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 64,
  parameter int GW      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ*DW-1:0] data_i,
  output logic [N_REQ-1:0]    ack_o,
  output logic                req_out,
  output logic [DW-1:0]       data_out,
  input  logic                ack_in,
  output logic [GW-1:0]       grant_id,
  output logic                busy,
  output logic                timeout_err,
  output logic [15:0]         txn_cnt
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;
  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [GW-1:0] pick;
  logic [GW-1:0] idx;
  logic          found;
  always_comb begin
    pick  = grant_id;
    idx   = grant_id;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = GW'((int'(grant_id) + i) % N_REQ);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ack_o       <= '0;
      req_out     <= 1'b0;
      data_out    <= '0;
      grant_id    <= GW'(N_REQ - 1);
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      txn_cnt     <= '0;
      timer       <= '0;
    end else begin
      case (state)
        S_IDLE: if (found) begin
          grant_id <= pick;
          data_out <= data_i[int'(pick)*DW +: DW];
          req_out  <= 1'b1;
          busy     <= 1'b1;
          timer    <= '0;
          state    <= S_REQ;
        end
        S_REQ: if (ack_in) begin
          ack_o[grant_id] <= 1'b1;
          state           <= S_ACK;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          // grant_id is kept so the aborted requester drops to lowest priority
          req_out     <= 1'b0;
          timeout_err <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end else begin
          timer <= timer + 1'b1;
        end
        S_ACK: if (!req_i[grant_id]) begin
          req_out <= 1'b0;
          state   <= S_REL;
        end
        S_REL: if (!ack_in) begin
          ack_o   <= '0;
          txn_cnt <= txn_cnt + 16'd1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_handshake_arbiter.sv
// tb_handshake_arbiter: requester agents, accumulator model and grant scoreboard around handshake_arbiter
module tb_handshake_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  ack_o;
  logic        req_out;
  logic [7:0]  data_out;
  logic        ack_in;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic [15:0] txn_cnt;
  int applied = 0;
  int miscompares = 0;
  logic [7:0] dat [4];
  int want [4];
  int done [4];
  logic [3:0] hold = 4'b0;
  logic [3:0] req_v = 4'b0;
  logic prev_ro = 1'b0;
  logic mon_prev = 1'b0;
  logic acc_en = 1'b1;
  logic s1, s2;
  logic [15:0] sum;
  logic [9:0] exp_q [$];
  assign req_i  = req_v;
  assign data_i = {dat[3], dat[2], dat[1], dat[0]};
  handshake_arbiter #(.N_REQ(4), .DW(8), .TIMEOUT(64), .GW(2)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i), .ack_o(ack_o),
    .req_out(req_out), .data_out(data_out), .ack_in(ack_in), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err), .txn_cnt(txn_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  // accumulator: 2-flop req sync, acks after sync, adds on each synced rise
  always @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0; s2 <= 1'b0; ack_in <= 1'b0; sum <= '0;
    end else begin
      s1 <= req_out;
      s2 <= s1;
      ack_in <= s2 & acc_en;
      if (s2 && acc_en && !ack_in) sum <= sum + {{8{data_out[7]}}, data_out};
    end
  end
  // requester agents: 4-phase handshakes, give up after a timed-out grant
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        req_v[k] = 1'b0; done[k] = want[k];
      end else if (req_v[k] && ack_o[k] && !hold[k]) begin
        req_v[k] = 1'b0; done[k]++;
      end else if (req_v[k] && int'(grant_id) == k && prev_ro && !req_out && !ack_o[k]) begin
        req_v[k] = 1'b0; done[k]++;
      end else if (!req_v[k] && !ack_o[k] && done[k] < want[k]) begin
        req_v[k] = 1'b1;
      end
    end
    prev_ro = req_out;
  end
  // scoreboard monitor: every downstream req rise must match the next expected grant
  always @(negedge clk) begin
    if (rst) mon_prev <= 1'b0;
    else begin
      if (req_out && !mon_prev) begin
        if (exp_q.size() == 0) check("sb_unexpected_grant", {22'd0, grant_id, data_out}, 32'hFFFF_FFFF);
        else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("sb_grant_id", {30'd0, grant_id}, {30'd0, e[9:8]});
          check("sb_data_out", {24'd0, data_out}, {24'd0, e[7:0]});
        end
      end
      mon_prev <= req_out;
    end
  end
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
  endtask
  task automatic issue(input int k, input logic [7:0] d);
    dat[k] = d;
    want[k]++;
    exp_q.push_back({2'(k), d});
  endtask
  task automatic wait_idle(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && !ack_in && !req_out && done[0] == want[0] && done[1] == want[1] &&
           done[2] == want[2] && done[3] == want[3];
    end
    check(nm, {31'd0, ok}, 32'd1);
  endtask
  initial begin
    int n, w;
    for (int k = 0; k < 4; k++) begin dat[k] = 8'h00; want[k] = 0; done[k] = 0; end
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ack_o", {28'd0, ack_o}, 32'd0);
    check("rst_req_out", {31'd0, req_out}, 32'd0);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("rst_txn_cnt", {16'd0, txn_cnt}, 32'd0);
    // T1 single transaction, one-cycle req latency
    @(posedge clk); #1 issue(0, 8'h05);
    @(posedge clk); #1;
    check("t1_req_i_up", {28'd0, req_i}, 32'h1);
    @(posedge clk); #1;
    check("t1_latency_req_out", {31'd0, req_out}, 32'd1);
    w = 0;
    while (ack_o == 4'b0 && w < 50) begin @(negedge clk); w++; end
    check("t1_ack_o", {28'd0, ack_o}, 32'h1);
    wait_idle("t1_complete");
    check("t1_txn_cnt", {16'd0, txn_cnt}, 32'd1);
    check("t1_sum", {16'd0, sum}, 32'h5);
    // T2 all four at once, signed sum
    do_reset();
    @(posedge clk); #1;
    issue(0, 8'h01); issue(1, 8'h02); issue(2, 8'h03); issue(3, 8'hFF);
    wait_idle("t2_complete");
    check("t2_txn_cnt", {16'd0, txn_cnt}, 32'd4);
    check("t2_sum", {16'd0, sum}, 32'h5);
    // T3 fairness: 0 and 2 keep re-requesting, grants must alternate
    do_reset();
    @(posedge clk); #1;
    dat[0] = 8'h10; dat[2] = 8'h20; want[0] += 3; want[2] += 3;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'd0, 8'h10}); exp_q.push_back({2'd2, 8'h20});
    end
    wait_idle("t3_complete");
    check("t3_txn_cnt", {16'd0, txn_cnt}, 32'd6);
    check("t3_sum", {16'd0, sum}, 32'h90);
    // T4 timeout with the accumulator silent
    do_reset();
    acc_en = 1'b0;
    @(posedge clk); #1 issue(1, 8'h33);
    w = 0;
    while (!req_out && w < 20) begin @(negedge clk); w++; end
    n = 0;
    while (req_out && n < 200) begin @(negedge clk); n++; end
    check("t4_cycles_in_req", n, 32'd64);
    check("t4_timeout_err", {31'd0, timeout_err}, 32'd1);
    check("t4_ack_o", {28'd0, ack_o}, 32'd0);
    check("t4_txn_cnt", {16'd0, txn_cnt}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("t4_err_sticky", {31'd0, timeout_err}, 32'd1);
    check("t4_no_regrant", {31'd0, req_out}, 32'd0);
    check("t4_grant_kept", {30'd0, grant_id}, 32'd1);
    acc_en = 1'b1;
    // T5 reset while parked in S_ACK
    do_reset();
    @(posedge clk); #1 hold[2] = 1'b1; issue(2, 8'h44);
    w = 0;
    while (ack_o != 4'b0100 && w < 50) begin @(negedge clk); w++; end
    check("t5_in_ack", {28'd0, ack_o}, 32'h4);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_ack_o", {28'd0, ack_o}, 32'd0);
    check("t5_req_out", {31'd0, req_out}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_grant_id", {30'd0, grant_id}, 32'd3);
    check("t5_txn_cnt", {16'd0, txn_cnt}, 32'd0);
    @(negedge clk); #1 rst = 1'b0; hold[2] = 1'b0;
    // T6 completion counter wrap
    @(negedge clk);
    force dut.txn_cnt = 16'hFFFF;
    #1 release dut.txn_cnt;
    @(posedge clk); #1 issue(3, 8'h7F);
    wait_idle("t6_complete");
    check("t6_txn_wrap", {16'd0, txn_cnt}, 32'd0);
    check("t6_sum", {16'd0, sum}, 32'h7F);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
